// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared LCD panel geometry, pixel type and fetch-path enums
package lcd_pkg;

  // Active area of the panel
  localparam int H_ACTIVE = 800;
  localparam int V_ACTIVE = 480;

  // Horizontal porches; these are shared with the sync/DE timing generator
  localparam int H_FP    = 88;
  localparam int H_SYNC  = 48;
  localparam int H_BP    = 256;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;

  // Vertical porches
  localparam int V_FP    = 13;
  localparam int V_SYNC  = 3;
  localparam int V_BP    = 29;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // RGB565 pixel
  localparam int PIX_W = 16;
  typedef logic [PIX_W-1:0] pix_t;

  // Line-fetch sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

  // Owner of the SRAM read that returns next cycle
  typedef enum logic [1:0] {
    TAG_NONE  = 2'd0,
    TAG_FETCH = 2'd1,
    TAG_HOST  = 2'd2
  } req_tag_t;

endpackage

// File: rtl/lcd_fb_addr_gen.sv
// rtl/lcd_fb_addr_gen.sv - frame-buffer line base, pixel index and line counters
module lcd_fb_addr_gen #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19,
  parameter int FB_BASE  = 0,
  parameter int X_W      = 10,
  parameter int L_W      = 9
) (
  input  logic              PixelClk,
  input  logic              nRST,
  input  logic              frame_load,
  input  logic              line_adv,
  input  logic              x_inc,
  output logic [X_W-1:0]    x,
  output logic [ADDR_W-1:0] addr,
  output logic              last_pix,
  output logic              next_line_ok
);

  logic [ADDR_W-1:0] base;
  logic [L_W-1:0]    line_idx;

  // Line base moves by one line stride per line_start; the counters stop at
  // V_ACTIVE so vertical blanking lines cannot walk the base off the buffer.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      base     <= ADDR_W'(FB_BASE);
      line_idx <= '0;
      x        <= '0;
    end else if (frame_load) begin
      base     <= ADDR_W'(FB_BASE);
      line_idx <= '0;
      x        <= '0;
    end else if (line_adv) begin
      x <= '0;
      if (line_idx < L_W'(V_ACTIVE)) begin
        base     <= base + ADDR_W'(H_ACTIVE);
        line_idx <= line_idx + 1'b1;
      end
    end else if (x_inc) begin
      x <= x + 1'b1;
    end
  end

  assign addr         = base + ADDR_W'(x);
  assign last_pix     = (x == X_W'(H_ACTIVE - 1));
  // True when the line that the next line_start selects is still inside the frame
  assign next_line_ok = (({1'b0, line_idx} + 1'b1) < (L_W + 1)'(V_ACTIVE));

endmodule

// File: rtl/lcd_fb_fetch_arbiter.sv
// rtl/lcd_fb_fetch_arbiter.sv - SRAM arbiter between LCD line fetch and host port
module lcd_fb_fetch_arbiter #(
  parameter int H_ACTIVE      = lcd_pkg::H_ACTIVE,
  parameter int V_ACTIVE      = lcd_pkg::V_ACTIVE,
  parameter int ADDR_W        = 19,
  parameter int DATA_W        = 16,
  parameter int FB_BASE       = 0,
  parameter int HOST_MAX_WAIT = 8
) (
  input  logic              PixelClk,
  input  logic              nRST,
  input  logic              frame_start,
  input  logic              line_start,
  input  logic              fetch_en,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              lb_we,
  output logic              lb_bank,
  output logic [9:0]        lb_addr,
  output logic [DATA_W-1:0] lb_wdata,
  output logic              disp_bank,
  output logic              underrun,
  output logic              busy
);

  import lcd_pkg::*;

  localparam int X_W = 10;
  localparam int L_W = $clog2(V_ACTIVE + 1);
  localparam int W_W = $clog2(HOST_MAX_WAIT + 1);

  fetch_state_t      state, state_nxt;
  req_tag_t          tag_d, tag_q;
  logic [X_W-1:0]    tag_x_q;
  logic              tag_bank_q;

  logic [X_W-1:0]    x;
  logic [ADDR_W-1:0] fetch_addr;
  logic              last_pix;
  logic              next_line_ok;

  logic [W_W-1:0]    wait_cnt;
  logic              host_pri;
  logic              fetch_issue;
  logic              host_issue;
  logic              line_adv;

  // frame_start wins a same-cycle collision, so only a lone line_start advances
  assign line_adv = line_start && !frame_start;

  lcd_fb_addr_gen #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .ADDR_W   (ADDR_W),
    .FB_BASE  (FB_BASE),
    .X_W      (X_W),
    .L_W      (L_W)
  ) u_addr_gen (
    .PixelClk     (PixelClk),
    .nRST         (nRST),
    .frame_load   (frame_start),
    .line_adv     (line_adv),
    .x_inc        (fetch_issue),
    .x            (x),
    .addr         (fetch_addr),
    .last_pix     (last_pix),
    .next_line_ok (next_line_ok)
  );

  // The fetch owns the SRAM while in FETCH except when the host has waited
  // the full guard interval; outside FETCH the host gets every slot.
  assign host_pri    = host_req && (wait_cnt == W_W'(HOST_MAX_WAIT));
  assign fetch_issue = (state == FETCH) && !host_pri;
  assign host_issue  = host_req && ((state != FETCH) || host_pri);
  assign host_gnt    = host_issue;

  // Drive the single SRAM port from whichever requester won this cycle
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (host_issue) begin
      mem_en    = 1'b1;
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_we ? host_wdata : '0;
    end else if (fetch_issue) begin
      mem_en   = 1'b1;
      mem_addr = fetch_addr;
    end
  end

  // Count cycles a host request has been blocked; saturates at the guard value
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      wait_cnt <= '0;
    end else if (host_issue) begin
      wait_cnt <= '0;
    end else if (host_req && (wait_cnt != W_W'(HOST_MAX_WAIT))) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Tag the read issued this cycle so its data can be routed when it returns
  always_comb begin
    tag_d = TAG_NONE;
    if (host_issue) begin
      tag_d = host_we ? TAG_NONE : TAG_HOST;
    end else if (fetch_issue) begin
      tag_d = TAG_FETCH;
    end
  end

  // Tag pipeline register: owner, pixel index and fill bank of the read in flight
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      tag_q      <= TAG_NONE;
      tag_x_q    <= '0;
      tag_bank_q <= 1'b0;
    end else begin
      tag_q      <= tag_d;
      tag_x_q    <= x;
      tag_bank_q <= lb_bank;
    end
  end

  // A fetch read whose bank was swapped away by an aborting line_start is dropped
  assign lb_we       = (tag_q == TAG_FETCH) && (tag_bank_q == lb_bank);
  assign lb_addr     = lb_we ? tag_x_q : '0;
  assign lb_wdata    = lb_we ? mem_rdata : '0;
  assign host_rvalid = (tag_q == TAG_HOST);
  assign host_rdata  = host_rvalid ? mem_rdata : '0;

  assign lb_bank = ~disp_bank;
  assign busy    = (state != IDLE);

  // Bank swap on each line_start and sticky flag for a line cut short
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      disp_bank <= 1'b1;
      underrun  <= 1'b0;
    end else if (line_adv) begin
      disp_bank <= ~disp_bank;
      if ((state == FETCH) || (state == DRAIN)) begin
        underrun <= 1'b1;
      end
    end
  end

  // Sequencer state register
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: frame_start, then line_start, override the line progress
  always_comb begin
    state_nxt = state;
    if (frame_start) begin
      state_nxt = fetch_en ? FETCH : IDLE;
    end else if (line_start) begin
      state_nxt = (next_line_ok && fetch_en) ? FETCH : IDLE;
    end else begin
      case (state)
        FETCH:   if (fetch_issue && last_pix) state_nxt = DRAIN;
        DRAIN:   state_nxt = HOLD;
        default: state_nxt = state;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_fb_fetch_arbiter.sv
// tb/tb_lcd_fb_fetch_arbiter.sv - directed self-checking bench for lcd_fb_fetch_arbiter
module tb_lcd_fb_fetch_arbiter;
  import lcd_pkg::*;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 16;

  logic              PixelClk = 1'b0;
  logic              nRST = 1'b0;
  logic              frame_start = 1'b0;
  logic              line_start = 1'b0;
  logic              fetch_en = 1'b1;
  logic              host_req = 1'b0;
  logic              host_we = 1'b0;
  logic [ADDR_W-1:0] host_addr = '0;
  logic [DATA_W-1:0] host_wdata = '0;
  logic              host_gnt, host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              lb_we, lb_bank;
  logic [9:0]        lb_addr;
  logic [DATA_W-1:0] lb_wdata;
  logic              disp_bank, underrun, busy;

  int   errors = 0;
  int   checks = 0;
  int   exp_x = 0;
  int   exp_base = 0;
  logic exp_disp = 1'b1;

  lcd_fb_fetch_arbiter #(
    .H_ACTIVE(800), .V_ACTIVE(480), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .FB_BASE(0), .HOST_MAX_WAIT(8)
  ) dut (
    .PixelClk(PixelClk), .nRST(nRST), .frame_start(frame_start), .line_start(line_start),
    .fetch_en(fetch_en), .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .lb_we(lb_we), .lb_bank(lb_bank),
    .lb_addr(lb_addr), .lb_wdata(lb_wdata), .disp_bank(disp_bank), .underrun(underrun),
    .busy(busy)
  );

  always #5 PixelClk = ~PixelClk;

  function automatic pix_t pat(input int a);
    pix_t v;
    v = pix_t'(a);
    return v ^ 16'h5A3C;
  endfunction

  // SRAM model: read data one cycle after a read, garbage otherwise
  always @(posedge PixelClk) begin
    if (mem_en && !mem_we) mem_rdata <= pat(int'(mem_addr));
    else                   mem_rdata <= 16'hDEAD;
  end

  task automatic test_reset();
    nRST = 1'b0;
    repeat (3) @(negedge PixelClk);
    nRST = 1'b1;
    #1;
    checks++; if (disp_bank !== 1'b1) begin errors++; $display("FAIL reset_disp_bank: got %b expected 1", disp_bank); end
    checks++; if (lb_bank !== 1'b0) begin errors++; $display("FAIL reset_lb_bank: got %b expected 0", lb_bank); end
    checks++; if ({mem_en, lb_we, busy, underrun, host_gnt, host_rvalid} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 000000", {mem_en, lb_we, busy, underrun, host_gnt, host_rvalid});
    end
  endtask

  task automatic test_first_line();
    @(negedge PixelClk); frame_start = 1'b1; #1;
    for (int k = 1; k <= 802; k++) begin
      @(negedge PixelClk); frame_start = 1'b0; #1;
      if (k <= 800) begin
        checks++; if (mem_en !== 1'b1 || mem_addr !== 19'(k - 1)) begin
          errors++; $display("FAIL first_addr k=%0d: got en=%b addr=%0d expected en=1 addr=%0d", k, mem_en, mem_addr, k - 1);
        end
      end else begin
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL first_idle_mem k=%0d: got %b expected 0", k, mem_en); end
      end
      if (k >= 2 && k <= 801) begin
        checks++; if (lb_we !== 1'b1 || lb_addr !== 10'(k - 2) || lb_wdata !== pat(k - 2) || lb_bank !== 1'b0) begin
          errors++; $display("FAIL first_lb k=%0d: got we=%b addr=%0d data=%h bank=%b expected we=1 addr=%0d data=%h bank=0",
                             k, lb_we, lb_addr, lb_wdata, lb_bank, k - 2, pat(k - 2));
        end
      end else begin
        checks++; if (lb_we !== 1'b0) begin errors++; $display("FAIL first_lb_idle k=%0d: got %b expected 0", k, lb_we); end
      end
    end
    checks++; if (dut.state !== HOLD || busy !== 1'b1) begin
      errors++; $display("FAIL first_hold: got state=%0d busy=%b expected state=%0d busy=1", dut.state, busy, HOLD);
    end
  endtask

  task automatic test_line_advance();
    @(negedge PixelClk); line_start = 1'b1; #1;
    @(negedge PixelClk); line_start = 1'b0; #1;
    exp_disp = 1'b0; exp_base = 800; exp_x = 0;
    checks++; if (disp_bank !== 1'b0 || lb_bank !== 1'b1) begin
      errors++; $display("FAIL adv_bank: got disp=%b lb=%b expected disp=0 lb=1", disp_bank, lb_bank);
    end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL adv_underrun: got %b expected 0", underrun); end
    checks++; if (mem_addr !== 19'(800) || lb_we !== 1'b0) begin
      errors++; $display("FAIL adv_start: got addr=%0d lb_we=%b expected addr=800 lb_we=0", mem_addr, lb_we);
    end
    exp_x = 1;
    @(negedge PixelClk); #1;
    checks++; if (mem_addr !== 19'(801) || lb_we !== 1'b1 || lb_addr !== 10'd0 || lb_bank !== 1'b1 || lb_wdata !== pat(800)) begin
      errors++; $display("FAIL adv_lb: got addr=%0d we=%b lb_addr=%0d bank=%b data=%h expected 801 1 0 1 %h",
                         mem_addr, lb_we, lb_addr, lb_bank, lb_wdata, pat(800));
    end
    exp_x = 2;
  endtask

  task automatic test_host_guard();
    for (int i = 0; i < 8; i++) begin
      @(negedge PixelClk); host_req = 1'b1; host_we = 1'b0; host_addr = 19'h01234; #1;
      checks++; if (host_gnt !== 1'b0 || mem_addr !== 19'(exp_base + exp_x)) begin
        errors++; $display("FAIL guard_wait i=%0d: got gnt=%b addr=%0d expected gnt=0 addr=%0d", i, host_gnt, mem_addr, exp_base + exp_x);
      end
      exp_x++;
    end
    @(negedge PixelClk); #1;
    checks++; if (host_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 19'h01234) begin
      errors++; $display("FAIL guard_gnt: got gnt=%b en=%b we=%b addr=%h expected 1 1 0 01234", host_gnt, mem_en, mem_we, mem_addr);
    end
    @(negedge PixelClk); host_req = 1'b0; #1;
    checks++; if (host_rvalid !== 1'b1 || host_rdata !== pat(32'h1234) || lb_we !== 1'b0) begin
      errors++; $display("FAIL guard_rdata: got rvalid=%b data=%h lb_we=%b expected 1 %h 0", host_rvalid, host_rdata, lb_we, pat(32'h1234));
    end
    checks++; if (host_gnt !== 1'b0 || mem_addr !== 19'(exp_base + exp_x)) begin
      errors++; $display("FAIL guard_resume: got gnt=%b addr=%0d expected 0 %0d", host_gnt, mem_addr, exp_base + exp_x);
    end
    exp_x++;
    @(negedge PixelClk); #1;
    checks++; if (lb_we !== 1'b1 || lb_addr !== 10'(exp_x - 1) || host_rvalid !== 1'b0) begin
      errors++; $display("FAIL guard_lb: got we=%b addr=%0d rvalid=%b expected 1 %0d 0", lb_we, lb_addr, host_rvalid, exp_x - 1);
    end
    exp_x++;
  endtask

  task automatic test_underrun_abort();
    while (exp_x < 400) begin
      @(negedge PixelClk); #1;
      checks++; if (mem_addr !== 19'(exp_base + exp_x)) begin
        errors++; $display("FAIL run_addr x=%0d: got %0d expected %0d", exp_x, mem_addr, exp_base + exp_x);
      end
      exp_x++;
    end
    @(negedge PixelClk); line_start = 1'b1; #1;
    checks++; if (mem_addr !== 19'(1200)) begin errors++; $display("FAIL abort_issue: got %0d expected 1200", mem_addr); end
    @(negedge PixelClk); line_start = 1'b0; #1;
    exp_disp = ~exp_disp; exp_base = 1600; exp_x = 1;
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL abort_underrun: got %b expected 1", underrun); end
    checks++; if (lb_we !== 1'b0) begin errors++; $display("FAIL abort_drop: got lb_we=%b expected 0", lb_we); end
    checks++; if (disp_bank !== exp_disp || lb_bank !== ~exp_disp || mem_addr !== 19'(1600)) begin
      errors++; $display("FAIL abort_restart: got disp=%b lb=%b addr=%0d expected %b %b 1600", disp_bank, lb_bank, mem_addr, exp_disp, ~exp_disp);
    end
    @(negedge PixelClk); #1;
    checks++; if (lb_we !== 1'b1 || lb_addr !== 10'd0 || lb_bank !== 1'b0 || lb_wdata !== pat(1600)) begin
      errors++; $display("FAIL abort_lb: got we=%b addr=%0d bank=%b data=%h expected 1 0 0 %h", lb_we, lb_addr, lb_bank, lb_wdata, pat(1600));
    end
    exp_x = 2;
  endtask

  task automatic test_same_cycle();
    @(negedge PixelClk); frame_start = 1'b1; line_start = 1'b1; #1;
    @(negedge PixelClk); frame_start = 1'b0; line_start = 1'b0; #1;
    exp_base = 0; exp_x = 1;
    checks++; if (disp_bank !== exp_disp) begin errors++; $display("FAIL same_bank: got %b expected %b", disp_bank, exp_disp); end
    checks++; if (mem_addr !== 19'd0 || mem_en !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL same_restart: got addr=%0d en=%b busy=%b expected 0 1 1", mem_addr, mem_en, busy);
    end
  endtask

  task automatic test_frame_end();
    for (int l = 1; l <= 479; l++) begin
      @(negedge PixelClk); line_start = 1'b1; #1;
      @(negedge PixelClk); line_start = 1'b0; #1;
      exp_disp = ~exp_disp;
      checks++; if (mem_addr !== 19'(l * 800) || disp_bank !== exp_disp) begin
        errors++; $display("FAIL frame_line l=%0d: got addr=%0d disp=%b expected %0d %b", l, mem_addr, disp_bank, l * 800, exp_disp);
      end
    end
    checks++; if (mem_addr !== 19'd383200) begin errors++; $display("FAIL frame_last_line: got %0d expected 383200", mem_addr); end
    @(negedge PixelClk); line_start = 1'b1; #1;
    @(negedge PixelClk); line_start = 1'b0; exp_disp = ~exp_disp;
    host_req = 1'b1; host_we = 1'b1; host_addr = 19'h7FFFF; host_wdata = 16'hBEEF; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frame_idle: got busy=%b expected 0", busy); end
    checks++; if (host_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 19'h7FFFF || mem_wdata !== 16'hBEEF) begin
      errors++; $display("FAIL frame_host_write: got gnt=%b we=%b addr=%h data=%h expected 1 1 7ffff beef", host_gnt, mem_we, mem_addr, mem_wdata);
    end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL frame_sticky: got %b expected 1", underrun); end
    @(negedge PixelClk); host_req = 1'b0; host_we = 1'b0; #1;
    checks++; if (mem_en !== 1'b0 || host_rvalid !== 1'b0) begin
      errors++; $display("FAIL frame_quiet: got en=%b rvalid=%b expected 0 0", mem_en, host_rvalid);
    end
  endtask

  task automatic test_reset_mid_fetch();
    @(negedge PixelClk); line_start = 1'b1; #1;
    @(negedge PixelClk); line_start = 1'b0; frame_start = 1'b1; #1;
    exp_disp = ~exp_disp;
    @(negedge PixelClk); frame_start = 1'b0; #1;
    @(negedge PixelClk); #1;
    checks++; if (busy !== 1'b1 || mem_en !== 1'b1 || lb_we !== 1'b1 || disp_bank !== 1'b0) begin
      errors++; $display("FAIL prereset: got busy=%b en=%b lb_we=%b disp=%b expected 1 1 1 0", busy, mem_en, lb_we, disp_bank);
    end
    nRST = 1'b0; #1;
    checks++; if ({host_gnt, host_rvalid, mem_en, mem_we, lb_we, lb_bank, busy, underrun} !== 8'b0) begin
      errors++; $display("FAIL rst_flags: got %b expected 00000000", {host_gnt, host_rvalid, mem_en, mem_we, lb_we, lb_bank, busy, underrun});
    end
    checks++; if (mem_addr !== '0 || lb_addr !== '0 || lb_wdata !== '0 || host_rdata !== '0 || mem_wdata !== '0) begin
      errors++; $display("FAIL rst_buses: got maddr=%0d laddr=%0d ldata=%h hdata=%h wdata=%h expected all 0", mem_addr, lb_addr, lb_wdata, host_rdata, mem_wdata);
    end
    checks++; if (disp_bank !== 1'b1) begin errors++; $display("FAIL rst_disp_bank: got %b expected 1", disp_bank); end
    @(negedge PixelClk); nRST = 1'b1; #1;
    checks++; if (busy !== 1'b0 || lb_we !== 1'b0) begin errors++; $display("FAIL rst_after: got busy=%b lb_we=%b expected 0 0", busy, lb_we); end
  endtask

  initial begin
    test_reset();
    test_first_line();
    test_line_advance();
    test_host_guard();
    test_underrun_abort();
    test_same_cycle();
    test_frame_end();
    test_reset_mid_fetch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_fb_fetch_arbiter.md
Name: lcd_fb_fetch_arbiter

Overview:
- Schedules access to the single-port pixel frame-buffer SRAM between the LCD refresh path and a host write/read port.
- Each line period it fetches the next H_ACTIVE pixels into one bank of a ping-pong line buffer while the LCD scans out the other bank.
- Sits between the sync/DE timing generator (which supplies frame_start/line_start) and the SRAM; the refresh fetch has priority, and host accesses fill idle slots under a starvation guard.

Parameters:
- H_ACTIVE, 800, pixels fetched per line.
- V_ACTIVE, 480, lines fetched per frame.
- ADDR_W, 19, SRAM word address width.
- DATA_W, 16, pixel width (RGB565).
- FB_BASE, 0, SRAM address of pixel (0,0).
- HOST_MAX_WAIT, 8, maximum cycles a pending host request may be blocked by the fetch.

Ports:
- PixelClk  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- frame_start  in  1  one-cycle pulse at the start of vertical blanking
- line_start  in  1  one-cycle pulse at the end of each active line (start of H front porch)
- fetch_en  in  1  level; 0 suppresses new fetches
- host_req  in  1  request, held until host_gnt
- host_we  in  1  1 = write
- host_addr  in  ADDR_W  word address
- host_wdata  in  DATA_W  write data
- host_gnt  out  1  one-cycle accept pulse
- host_rvalid  out  1  read data valid, one cycle after a read grant
- host_rdata  out  DATA_W  read data
- mem_en  out  1  SRAM cycle enable
- mem_we  out  1  SRAM write
- mem_addr  out  ADDR_W  SRAM address
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM read data, valid one cycle after mem_en && !mem_we
- lb_we  out  1  line-buffer write strobe
- lb_bank  out  1  bank being filled
- lb_addr  out  10  pixel index within the line
- lb_wdata  out  DATA_W  pixel data
- disp_bank  out  1  bank the LCD reads; always equals ~lb_bank
- underrun  out  1  sticky; a fetch was incomplete at line_start
- busy  out  1  FSM not IDLE

Behaviour:
- Reset: all outputs 0; disp_bank=1 so lb_bank=0; FSM=IDLE; line_idx=0; base=FB_BASE; wait_cnt=0.
- FSM states:
  - IDLE: no fetch pending.
  - FETCH: issuing reads x=0..H_ACTIVE-1.
  - DRAIN: waiting one cycle for the last read to return.
  - HOLD: line complete; waiting for line_start.
- frame_start (fetch_en=1): line_idx<=0, base<=FB_BASE, go to FETCH with x=0. Overrides every other state, including an in-progress fetch. underrun is not set.
- line_start:
  - Toggles disp_bank (lb_bank follows).
  - line_idx and base advance: base+=H_ACTIVE, using an adder, not a multiplier.
  - If the new line_idx<V_ACTIVE and fetch_en=1: FETCH with x=0; otherwise IDLE.
  - If line_start arrives in FETCH or DRAIN: set underrun, abort the remaining reads, and restart as above.
- Same-cycle frame_start and line_start: frame_start wins and no bank toggle occurs.
- Arbitration, per cycle:
  - In FETCH, a fetch read is issued (mem_addr=base+x, x++) unless host_req && wait_cnt==HOST_MAX_WAIT, in which case the host is issued and the fetch stalls one cycle.
  - Outside FETCH, a pending host request is issued immediately.
  - wait_cnt increments while host_req is high and the host is not granted; it clears on grant.
- host_gnt pulses in the same cycle as the host's mem_en. For reads, host_rvalid/host_rdata follow one cycle later.
- Fetch reads: one cycle after issue, lb_we=1, lb_addr=x of that read, lb_wdata=mem_rdata, lb_bank=current fill bank. After issuing x=H_ACTIVE-1, go to DRAIN, then HOLD.
- A per-cycle tag pipeline (fetch / host-read / none) routes returning data. An in-flight fetch read at an abort is discarded: lb_we is suppressed if the tag's bank differs from the current lb_bank.
- Host writes never collide with fetch writes, because the line buffer is write-only from this block.
- fetch_en=0 mid-FETCH: finish the current line, then do not start new lines.
- Fetch throughput is at most 1 pixel/cycle. With worst-case guard stalls a line takes ≤ H_ACTIVE*(HOST_MAX_WAIT+1)/HOST_MAX_WAIT + 1 cycles, which must fit the 1192-cycle line period.
- Reset mid-operation: immediate return to reset values; any in-flight SRAM read is ignored.

Decomposition:
- Shared package lcd_pkg:
  - H_ACTIVE/V_ACTIVE and the porch constants shared with the timing generator.
  - typedef pix_t (DATA_W).
  - enum fetch_state_t {IDLE, FETCH, DRAIN, HOLD}.
  - enum req_tag_t {TAG_NONE, TAG_FETCH, TAG_HOST}.
- One natural sub-module: lcd_fb_addr_gen, covering the base/x/line_idx counters, frame/line advance and the last-pixel flag. Arbitration, tag pipeline and FSM stay in the top.

Test Plan:
- Reset, then frame_start, no host traffic:
  - mem_addr runs 0..799 on consecutive cycles.
  - lb_we pulses 800 times with lb_addr 0..799, lb_bank=0.
  - FSM reaches HOLD at cycle 802.
- line_start after the line is complete:
  - disp_bank toggles 1→0.
  - Next fetch addresses start at 800 into lb_bank=1; underrun stays 0.
- Host read held during FETCH (HOST_MAX_WAIT=8):
  - host_gnt is granted exactly 8 cycles after host_req rises.
  - The fetch stalls 1 cycle; host_rvalid arrives 1 cycle later with the SRAM word.
  - The fetch resumes at the next x.
- line_start while x=400:
  - underrun=1.
  - The in-flight pixel is not written.
  - A new fetch starts at base+800 into the toggled bank.
- 480 line_starts after frame_start:
  - Line 479 is fetched from address 383200.
  - On the following line_start the FSM goes IDLE and host requests are granted the same cycle.
- Same-cycle frame_start and line_start mid-frame:
  - disp_bank is unchanged.
  - The fetch restarts at address 0.
- nRST asserted mid-FETCH:
  - All outputs are 0 and disp_bank=1 within the same cycle.
